bcd_serial_adder: RTL
=====================

Name: bcd_serial_adder

Overview:
Digit-serial multi-digit BCD adder. It adds two packed DIGITS-digit BCD operands one decimal digit per clock, least significant digit first. The inter-digit carry is held in a register. A start/busy/done handshake frames each operation. It feeds the single-digit BCD add function (a, b, cin → corrected digit, carry) and consumes its result. The block sits between operand registers and the display/result path.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1). Operand and sum width is 4*DIGITS.

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a new addition; sampled only in IDLE
a  in  4*DIGITS  operand A, packed BCD, digit 0 = bits [3:0]
b  in  4*DIGITS  operand B, packed BCD
cin  in  1  carry into digit 0
busy  out  1  high while digits are being processed (RUN)
done  out  1  single-cycle pulse: sum/cout/invalid valid
sum  out  4*DIGITS  packed BCD result
cout  out  1  decimal carry out of the most significant digit
invalid  out  1  some digit of latched a or b was greater than 9

Behaviour:
- Reset (rst=1 at an edge, any state): state←IDLE. busy, done, sum, cout and invalid all ←0. The carry register, digit index and operand latches ←0. Reset during RUN or DONE abandons the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge: latch a, b and cin into internal registers; index←0; carry←cin; state←RUN.
  - At the same edge, invalid←1 if any latched nibble of a or b is greater than 9, else 0.
  - Otherwise remain in IDLE.
- RUN (busy=1): at each edge, process the digit selected by index.
  - raw = a_d + b_d + carry (5-bit).
  - If raw > 9: digit = (raw + 6)[3:0] and carry←1. Otherwise digit = raw[3:0] and carry←0.
  - Write the digit into the internal result register at position index, then index←index+1.
  - On the edge that processes digit DIGITS-1: sum←complete result, cout←final carry, state←DONE.
- DONE: done=1 and busy=0 for exactly one cycle; next edge state←IDLE.
- Latency: start sampled at edge E0. busy is high for DIGITS cycles after E0. done is high in the cycle following edge E(DIGITS). The next start can be accepted at edge E(DIGITS+2).
- sum, cout and invalid change only on the transition into DONE, and on reset. invalid is the exception: it also updates at start acceptance. sum and cout hold their values through IDLE until the next DONE, so partial results are never visible.
- start while in RUN or DONE is ignored. The operands in flight are unaffected, and changes on a, b or cin after acceptance have no effect.
- Out-of-range digits are not rejected. The arithmetic rule above is applied as written and invalid flags the condition. Example: raw = 10..31 always yields carry=1.
- Simultaneous rst and start: reset wins and the operation is not accepted.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. DIGITS=4, a=0x1234, b=0x4321, cin=0, 1-cycle start → busy high 4 cycles; done in cycle 5 after start edge; sum=0x5555, cout=0, invalid=0.
2. a=0x9999, b=0x0001, cin=0 → sum=0x0000, cout=1, invalid=0. Carry ripples through every digit.
3. a=0x0999, b=0x0000, cin=1 → sum=0x1000, cout=0. Then a=0x5000, b=0x5000, cin=0 → sum=0x0000, cout=1.
4. a=0x00A5, b=0x0001, cin=0 → invalid=1; sum=0x0106, cout=0 (digit1: 10 → 0 carry 1; digit2: 0+0+1 → 1).
5. Start a=0x1111, b=0x1111, then pulse start with a=0x9999, b=0x9999 during RUN and during DONE → both ignored; sum=0x2222, cout=0; exactly one done pulse.
6. Assert rst for one edge during the second RUN cycle → next cycle all outputs 0, state IDLE, no done. A following start with a=0x0050, b=0x0050 → sum=0x0100, cout=0.

Source files
------------

// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder.
// The master side issues requests. The slave side is the adder itself.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  invalid;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, invalid
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder. It processes one decimal digit per clock, least significant digit first.
// The sum, carry-out and invalid flag are published together when the operation completes.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    bcd_serial_adder_if.slave   bus
);
    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Returns {carry, digit}. Out-of-range inputs follow the same rule: any raw value above 9 carries.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x, input logic [3:0] y, input logic c);
        logic [4:0] raw;
        logic [4:0] adj;
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        adj = raw + 5'd6;
        if (raw > 5'd9) begin
            bcd_digit_add = {1'b1, adj[3:0]};
        end else begin
            bcd_digit_add = {1'b0, raw[3:0]};
        end
    endfunction

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        has_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                has_bad_digit = 1'b1;
            end
        end
    endfunction

    logic [1:0]      state_q,   state_d;
    logic [W-1:0]    a_q,       a_d;
    logic [W-1:0]    b_q,       b_d;
    logic            carry_q,   carry_d;
    logic [IDXW-1:0] idx_q,     idx_d;
    logic [W-1:0]    res_q,     res_d;
    logic [W-1:0]    sum_q,     sum_d;
    logic            cout_q,    cout_d;
    logic            invalid_q, invalid_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic [4:0]      dig_s;

    // Next-state and datapath logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        res_d     = res_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        dig_s     = bcd_digit_add(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], carry_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d   = ST_RUN;
                    a_d       = bus.a;
                    b_d       = bus.b;
                    carry_d   = bus.cin;
                    idx_d     = '0;
                    invalid_d = has_bad_digit(bus.a) | has_bad_digit(bus.b);
                    busy_d    = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d[4*idx_q +: 4] = dig_s[3:0];
                carry_d             = dig_s[4];
                idx_d               = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    // res_d already holds the final digit, so sum is published whole.
                    state_d = ST_DONE;
                    sum_d   = res_d;
                    cout_d  = dig_s[4];
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            res_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            carry_q   <= carry_d;
            idx_q     <= idx_d;
            res_q     <= res_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sum     = sum_q;
    assign bus.cout    = cout_q;
    assign bus.invalid = invalid_q;
endmodule
